capture_sequencer: RTL and testbench

Sequences the RF sample data generator and paces its output into the FX3 GPIF in fixed-size bursts. Drives the generator's collect/read/test-mode controls from host start/stop and test requests. Issues read strobes only when the FX3 has a free DMA buffer and the generator has data. Sits between the host-control GPIO and the data generator / 16-bit sample path in the FPGA top level.

---
 rtl/capture_seq_pkg.sv | 22 ++
 rtl/pipe_delay.sv | 30 +++
 rtl/capture_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_capture_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/capture_seq_pkg.sv
// Shared definitions for capture_sequencer: state encoding, default parameters and
// the completed-burst counter width.
package capture_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle      = 3'd0;
  localparam state_t StArm       = 3'd1;
  localparam state_t StWaitReady = 3'd2;
  localparam state_t StBurst     = 3'd3;
  localparam state_t StGap       = 3'd4;
  localparam state_t StDrain     = 3'd5;

  localparam int unsigned BurstLenDef  = 8192;
  localparam int unsigned ArmCyclesDef = 16;
  localparam int unsigned GapCyclesDef = 4;
  localparam int unsigned PipeLatDef   = 1;
  localparam int unsigned OvfLimitDef  = 4096;

  localparam int unsigned BurstCntW = 16;

endpackage

// File: rtl/pipe_delay.sv
// Fixed-latency shift register with asynchronous active-high reset; used to align the
// read strobe and last-word flag with the data emerging from the generator.
module pipe_delay #(
  parameter int unsigned Depth = 1,
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage_q [Depth];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < Depth; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[Depth-1];

endmodule

// File: rtl/capture_sequencer.sv
// Sequences the sample generator and paces its output into the FX3 in full bursts.
// Optional FX3 stall detection is built when CAPTURE_OVERFLOW_DETECT_EN is defined.
module capture_sequencer
  import capture_seq_pkg::*;
#(
  parameter int unsigned BURST_LEN  = BurstLenDef,
  parameter int unsigned ARM_CYCLES = ArmCyclesDef,
  parameter int unsigned GAP_CYCLES = GapCyclesDef,
  parameter int unsigned PIPE_LAT   = PipeLatDef,
  parameter int unsigned OVF_LIMIT  = OvfLimitDef
) (
  input  logic                 inclk,
  input  logic                 reset,
  input  logic                 startCapture,
  input  logic                 testModeReq,
  input  logic                 fx3Ready,
  input  logic                 dataAvailable,
  output logic                 collectData,
  output logic                 readData,
  output logic                 testMode,
  output logic                 fx3Write,
  output logic                 fx3EndBurst,
  output logic                 capturing,
  output logic [BurstCntW-1:0] burstCount,
  output logic                 overflow
);

  localparam logic [15:0] WordLast = 16'(BURST_LEN - 1);

  state_t                state_q, state_d;
  logic [31:0]           phase_q, phase_d, phase_inc;
  logic [15:0]           word_q, word_d;
  logic [BurstCntW-1:0]  burst_cnt_q, burst_cnt_d;
  logic                  test_mode_q, test_mode_d;
  logic                  read, last_word;
  logic [1:0]            pipe_out;

  assign phase_inc = phase_q + 32'd1;
  assign read      = (state_q == StBurst) && dataAvailable;
  assign last_word = read && (word_q == WordLast);

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    word_d      = word_q;
    burst_cnt_d = burst_cnt_q;
    test_mode_d = test_mode_q;
    case (state_q)
      StIdle: begin
        if (startCapture) begin
          test_mode_d = testModeReq;
          burst_cnt_d = '0;
          phase_d     = '0;
          state_d     = StArm;
        end
      end
      StArm: begin
        if (phase_inc >= ARM_CYCLES) begin
          phase_d = '0;
          state_d = StWaitReady;
        end else begin
          phase_d = phase_inc;
        end
      end
      StWaitReady: begin
        // A stop request wins over starting another burst.
        if (!startCapture) begin
          phase_d = '0;
          state_d = StDrain;
        end else if (fx3Ready && dataAvailable) begin
          word_d  = '0;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (read) begin
          if (last_word) begin
            burst_cnt_d = burst_cnt_q + BurstCntW'(1);
            phase_d     = '0;
            state_d     = StGap;
          end else begin
            word_d = word_q + 16'd1;
          end
        end
      end
      StGap: begin
        if (phase_inc >= GAP_CYCLES) begin
          phase_d = '0;
          state_d = StWaitReady;
        end else begin
          phase_d = phase_inc;
        end
      end
      StDrain: begin
        // Keep the generator enabled until in-flight words have left the pipe.
        if (phase_inc >= PIPE_LAT) begin
          phase_d = '0;
          state_d = StIdle;
        end else begin
          phase_d = phase_inc;
        end
      end
      default: begin
        phase_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge inclk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      phase_q     <= '0;
      word_q      <= '0;
      burst_cnt_q <= '0;
      test_mode_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      word_q      <= word_d;
      burst_cnt_q <= burst_cnt_d;
      test_mode_q <= test_mode_d;
    end
  end

  pipe_delay #(
    .Depth (PIPE_LAT),
    .Width (2)
  ) u_pipe_delay (
    .clk_i (inclk),
    .rst_i (reset),
    .d_i   ({read, last_word}),
    .q_o   (pipe_out)
  );

`ifdef CAPTURE_OVERFLOW_DETECT_EN
  localparam int unsigned StallW = $clog2(OVF_LIMIT + 1);
  localparam logic [StallW-1:0] StallLast = StallW'(OVF_LIMIT - 1);

  logic [StallW-1:0] stall_q, stall_d;
  logic              overflow_q, overflow_d;
  logic              stalled;

  assign stalled = (state_q == StWaitReady) && !fx3Ready;

  always_comb begin
    stall_d    = '0;
    overflow_d = overflow_q;
    if (state_q == StIdle && startCapture) begin
      overflow_d = 1'b0;
    end
    if (stalled && (stall_q >= StallLast)) begin
      overflow_d = 1'b1;
    end
    // Saturate once the limit is hit; reset whenever WAIT_READY is left.
    if (state_q == StWaitReady && state_d == StWaitReady) begin
      stall_d = stall_q;
      if (stalled && (stall_q <= StallLast)) begin
        stall_d = stall_q + StallW'(1);
      end
    end
  end

  always_ff @(posedge inclk or posedge reset) begin
    if (reset) begin
      stall_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      stall_q    <= stall_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`else
  logic unused_ovf_limit;
  assign unused_ovf_limit = ^OVF_LIMIT;
  assign overflow = 1'b0;
`endif

  assign collectData = (state_q != StIdle);
  assign capturing   = (state_q != StIdle);
  assign readData    = read;
  assign testMode    = test_mode_q;
  assign burstCount  = burst_cnt_q;
  assign fx3Write    = pipe_out[1];
  assign fx3EndBurst = pipe_out[0];

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: a per-cycle vector table for the main burst flow
// plus hand-written sequences for stall overflow, test-mode latch, counter wrap and reset.
module tb_capture_sequencer;

  localparam int unsigned BL = 4;
  localparam int unsigned AC = 2;
  localparam int unsigned GC = 1;
  localparam int unsigned PL = 1;
  localparam int unsigned OL = 8;

`ifdef CAPTURE_OVERFLOW_DETECT_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic        inclk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        tmreq = 1'b0;
  logic        rdy   = 1'b0;
  logic        avail = 1'b0;
  logic        collectData, readData, testMode, fx3Write, fx3EndBurst, capturing, overflow;
  logic [15:0] burstCount;
  logic [6:0]  flags_now;

  int errors = 0;
  int checks = 0;

  capture_sequencer #(
    .BURST_LEN  (BL),
    .ARM_CYCLES (AC),
    .GAP_CYCLES (GC),
    .PIPE_LAT   (PL),
    .OVF_LIMIT  (OL)
  ) dut (
    .inclk         (inclk),
    .reset         (reset),
    .startCapture  (start),
    .testModeReq   (tmreq),
    .fx3Ready      (rdy),
    .dataAvailable (avail),
    .collectData   (collectData),
    .readData      (readData),
    .testMode      (testMode),
    .fx3Write      (fx3Write),
    .fx3EndBurst   (fx3EndBurst),
    .capturing     (capturing),
    .burstCount    (burstCount),
    .overflow      (overflow)
  );

  always #5 inclk = ~inclk;

  assign flags_now = {collectData, readData, fx3Write, fx3EndBurst, capturing, testMode, overflow};

  // in = {start, tmreq, rdy, avail}; flags = {collect, read, write, end, capt, tm, ovf}
  typedef struct {
    logic [3:0]  in;
    logic [6:0]  flags;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [32];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge inclk);
  endtask

  initial begin
    vecs[0]  = '{4'b1011, 7'b0000000, 16'd0};  // IDLE sees start
    vecs[1]  = '{4'b1011, 7'b1000100, 16'd0};  // ARM
    vecs[2]  = '{4'b1011, 7'b1000100, 16'd0};  // ARM
    vecs[3]  = '{4'b1011, 7'b1000100, 16'd0};  // WAIT_READY
    vecs[4]  = '{4'b1011, 7'b1100100, 16'd0};  // read w0
    vecs[5]  = '{4'b1011, 7'b1110100, 16'd0};
    vecs[6]  = '{4'b1011, 7'b1110100, 16'd0};
    vecs[7]  = '{4'b1011, 7'b1110100, 16'd0};  // read w3
    vecs[8]  = '{4'b1011, 7'b1011100, 16'd1};  // GAP, end burst
    vecs[9]  = '{4'b1011, 7'b1000100, 16'd1};  // WAIT_READY
    vecs[10] = '{4'b1011, 7'b1100100, 16'd1};  // second burst w0
    vecs[11] = '{4'b1011, 7'b1110100, 16'd1};  // w1
    vecs[12] = '{4'b1010, 7'b1010100, 16'd1};  // stall
    vecs[13] = '{4'b1010, 7'b1000100, 16'd1};
    vecs[14] = '{4'b1010, 7'b1000100, 16'd1};
    vecs[15] = '{4'b1011, 7'b1100100, 16'd1};  // w2
    vecs[16] = '{4'b1011, 7'b1110100, 16'd1};  // w3
    vecs[17] = '{4'b1011, 7'b1011100, 16'd2};  // GAP
    vecs[18] = '{4'b1011, 7'b1000100, 16'd2};  // WAIT_READY
    vecs[19] = '{4'b1011, 7'b1100100, 16'd2};  // third burst w0
    vecs[20] = '{4'b0011, 7'b1110100, 16'd2};  // stop ignored mid-burst
    vecs[21] = '{4'b0011, 7'b1110100, 16'd2};
    vecs[22] = '{4'b0011, 7'b1110100, 16'd2};
    vecs[23] = '{4'b0011, 7'b1011100, 16'd3};  // GAP
    vecs[24] = '{4'b0011, 7'b1000100, 16'd3};  // WAIT_READY -> DRAIN
    vecs[25] = '{4'b1011, 7'b1000100, 16'd3};  // DRAIN ignores start
    vecs[26] = '{4'b1011, 7'b0000000, 16'd3};  // IDLE honours start
    vecs[27] = '{4'b0011, 7'b1000100, 16'd0};  // ARM, count cleared
    vecs[28] = '{4'b0011, 7'b1000100, 16'd0};
    vecs[29] = '{4'b0011, 7'b1000100, 16'd0};  // WAIT_READY -> DRAIN
    vecs[30] = '{4'b0011, 7'b1000100, 16'd0};  // DRAIN
    vecs[31] = '{4'b0011, 7'b0000000, 16'd0};  // IDLE

    // Reset state
    cyc();
    #1;
    chk("reset_flags", 32'(flags_now), 32'd0);
    chk("reset_count", 32'(burstCount), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 32; i++) begin
      cyc();
      {start, tmreq, rdy, avail} = vecs[i].in;
      #1;
      chk($sformatf("vec%0d_flags", i), 32'(flags_now), 32'(vecs[i].flags));
      chk($sformatf("vec%0d_count", i), 32'(burstCount), 32'(vecs[i].cnt));
    end

    // Test-mode latch and FX3 stall overflow
    cyc();
    start = 1'b1; tmreq = 1'b1; rdy = 1'b0; avail = 1'b1;
    #1;
    chk("tm_idle_collect", 32'(collectData), 32'd0);
    cyc();
    tmreq = 1'b0;
    #1;
    chk("tm_latched", 32'(testMode), 32'd1);
    chk("arm_collect", 32'(collectData), 32'd1);
    repeat (9) cyc();
    #1;
    chk("ovf_before_limit", 32'(overflow), 32'd0);
    chk("stall_no_read", 32'(readData), 32'd0);
    cyc();
    #1;
    chk("ovf_at_limit", 32'(overflow), 32'(OVF_EXP));
    rdy = 1'b1;
    cyc();
    #1;
    chk("burst_after_stall", 32'(readData), 32'd1);
    chk("ovf_sticky", 32'(overflow), 32'(OVF_EXP));
    chk("tm_hold", 32'(testMode), 32'd1);
    start = 1'b0;
    for (int n = 0; n < 40 && capturing; n++) cyc();
    #1;
    chk("drain_to_idle", 32'(capturing), 32'd0);
    chk("stop_burst_count", 32'(burstCount), 32'd1);
    chk("ovf_held_idle", 32'(overflow), 32'(OVF_EXP));
    chk("tm_hold_idle", 32'(testMode), 32'd1);

    // Counter wrap, then asynchronous reset mid-burst
    cyc();
    start = 1'b1; tmreq = 1'b0; rdy = 1'b1; avail = 1'b1;
    cyc();
    #1;
    chk("tm_relatch", 32'(testMode), 32'd0);
    chk("ovf_cleared", 32'(overflow), 32'd0);
    chk("cnt_cleared", 32'(burstCount), 32'd0);
    force dut.burst_cnt_q = 16'hFFFF;
    repeat (3) cyc();
    #1;
    chk("wrap_first_read", 32'(readData), 32'd1);
    repeat (3) cyc();
    release dut.burst_cnt_q;
    cyc();
    #1;
    chk("wrap", 32'(burstCount), 32'd0);
    chk("wrap_end", 32'(fx3EndBurst), 32'd1);
    repeat (3) cyc();
    #1;
    chk("pre_reset_read", 32'(readData), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_reset_flags", 32'(flags_now), 32'd0);
    chk("async_reset_count", 32'(burstCount), 32'd0);
    cyc();
    #1;
    chk("reset_hold", 32'(flags_now), 32'd0);
    reset = 1'b0;
    cyc();
    #1;
    chk("restart_arm", 32'(collectData), 32'd1);
    chk("restart_count", 32'(burstCount), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
